ps2_voice_scheduler: RTL
========================

Name: ps2_voice_scheduler

Overview:
- Consumes the raw PS/2 scan-code byte stream from PS2_Controller (received_data / received_data_en).
- Parses Set-2 make/break/extended sequences and maps the piano-row keys to MIDI notes with an octave register.
- Schedules held notes onto NUM_VOICES synth voice slots, stealing the oldest voice when all slots are busy.
- Sits between the PS/2 front end and the synth voice datapath; it is the sole owner of voice assignment.

Parameters:
- NUM_VOICES, 4, number of voice slots (2..8).
- OCT_DEFAULT, 4, octave register value after reset (0..7).

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- received_data  in  8  scan-code byte from PS2_Controller.
- received_data_en  in  1  one-cycle strobe; received_data is valid in that cycle.
- voice_active  out  NUM_VOICES  bit v = slot v is sounding.
- voice_note  out  7*NUM_VOICES  slot v MIDI note in bits [7v+6:7v].
- evt_valid  out  1  one-cycle pulse: a slot changed.
- evt_voice  out  3  index of the slot that changed.
- evt_on  out  1  1 = slot (re)assigned, 0 = slot released.
- octave  out  3  current octave register.

Behaviour:
- Reset: voice_active=0, voice_note=0, evt_valid=0, evt_voice=0, evt_on=0, octave=OCT_DEFAULT, parser=IDLE, all age ranks=0. Reset overrides a same-cycle strobe.
- Only cycles with received_data_en=1 advance the parser. Outputs are registered and update in the cycle after the strobe (latency 1).
- Parser FSM:
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte = make(code).
  - BRK: byte = break(code) -> IDLE.
  - EXT: F0 -> EXT_BRK; else discard -> IDLE.
  - EXT_BRK: discard -> IDLE.
  - Extended keys never produce actions.
- Key map (make/break index 0..12): 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11, 42=12. All other codes are ignored, except the octave keys below.
- Octave keys:
  - make 1A: octave-1, saturating at 0.
  - make 22: octave+1, saturating at 7.
  - Breaks of 1A/22 are ignored.
  - An octave change does not alter slots already sounding.
- Note = 12*(octave+1) + index, 7 bits, max 8*12+12=108.
- Note-on (make of a mapped key):
  - If any active slot already holds that note (typematic repeat): no change, no event.
  - Else allocate the lowest-index inactive slot.
  - If no slot is inactive, steal the active slot with the highest age rank; ties go to the lowest index.
  - Allocated slot: active=1, note written, rank=0. Every other active slot's rank increments, saturating at NUM_VOICES-1.
  - Emit evt_valid=1, evt_on=1, evt_voice=slot.
- Note-off (break of a mapped key):
  - Note is computed with the current octave.
  - Every active slot holding that note clears active (rank preserved, irrelevant when inactive). evt_valid=1, evt_on=0, evt_voice = lowest such slot.
  - No matching slot: no event. Other slots' ranks are unchanged.
- evt_valid is high for exactly one cycle per event; at most one event per strobe.
- Strobe during reset: discarded.
- A break that arrives after an octave change does not release the old-octave note. That note stays until it is stolen or reset is asserted. This is intentional and documented.

Test Plan:
- Reset, then strobe 1C: voice_active=0001, voice_note[6:0]=60, evt_valid pulse with evt_voice=0, evt_on=1, exactly 1 cycle after the strobe.
- Make 1C, 1D, 1B, 24: slots 0..3 = 60, 61, 62, 63. Then make 23: slot 0 (oldest) is stolen, note=64, evt_on=1, evt_voice=0, voice_active stays 1111.
- Make 1C, then 1C repeated 5 times: one event only, voice_active=0001.
- Make 1C, then F0 1C: voice_active=0000, evt_on=0, evt_voice=0. Then F0 1C again: no event.
- E0 75, then E0 F0 75: no events, parser returns to IDLE. Next 1C makes note 60.
- Strobe 22 four times: octave saturates at 7, then make 1C gives note 96. Strobe 1A eight times: octave=0, make 1D gives note 13. Reset mid-sequence (after F0): the next 1C is treated as a make.

Source files
------------

// File: rtl/ps2_voice_scheduler.sv
// PS/2 Set-2 scan-code parser and polyphonic voice scheduler.
// Piano-row keys become MIDI notes, which are placed on voice slots; when every slot is busy, the oldest slot is stolen.
module ps2_voice_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int OCT_DEFAULT = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      reset,
  input  logic [7:0]                received_data,
  input  logic                      received_data_en,
  output logic [NUM_VOICES-1:0]     voice_active,
  output logic [7*NUM_VOICES-1:0]   voice_note,
  output logic                      evt_valid,
  output logic [2:0]                evt_voice,
  output logic                      evt_on,
  output logic [2:0]                octave
);

  // Byte interface: received_data is consumed only in cycles where
  // received_data_en is high. There is no backpressure, and every strobe is
  // accepted. An event pulse appears in the cycle after the strobe.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_ODN  = 8'h1A;
  localparam logic [7:0] CODE_OUP  = 8'h22;
  localparam logic [2:0] RANK_MAX  = 3'(NUM_VOICES - 1);
  localparam logic [2:0] OCT_RST   = 3'(OCT_DEFAULT);

  state_t                         state_q, state_d;
  logic [2:0]                     oct_q, oct_d;
  logic [NUM_VOICES-1:0]          active_q, active_d;
  logic [NUM_VOICES-1:0][6:0]     note_q, note_d;
  logic [NUM_VOICES-1:0][2:0]     rank_q, rank_d;
  logic                           evt_valid_q, evt_valid_d;
  logic [2:0]                     evt_voice_q, evt_voice_d;
  logic                           evt_on_q, evt_on_d;

  logic                           do_make;
  logic                           do_break;
  logic                           key_hit;
  logic [3:0]                     key_idx;
  logic [6:0]                     key_note;
  logic [NUM_VOICES-1:0]          match;
  logic                           free_found;
  logic [2:0]                     free_slot;
  logic [2:0]                     steal_slot;
  logic [2:0]                     steal_rank;
  logic [2:0]                     alloc_slot;
  logic                           match_found;
  logic [2:0]                     match_slot;

  always_comb begin
    key_hit = 1'b1;
    key_idx = 4'd0;
    case (received_data)
      8'h1C:   key_idx = 4'd0;
      8'h1D:   key_idx = 4'd1;
      8'h1B:   key_idx = 4'd2;
      8'h24:   key_idx = 4'd3;
      8'h23:   key_idx = 4'd4;
      8'h2B:   key_idx = 4'd5;
      8'h2C:   key_idx = 4'd6;
      8'h34:   key_idx = 4'd7;
      8'h35:   key_idx = 4'd8;
      8'h33:   key_idx = 4'd9;
      8'h3C:   key_idx = 4'd10;
      8'h3B:   key_idx = 4'd11;
      8'h42:   key_idx = 4'd12;
      default: key_hit = 1'b0;
    endcase
    key_note = 7'(oct_q) * 7'd12 + 7'd12 + {3'b000, key_idx};
  end

  // The slot search runs every cycle. Its result is used only when a mapped key is seen.
  always_comb begin
    match       = '0;
    free_found  = 1'b0;
    free_slot   = 3'd0;
    match_found = 1'b0;
    match_slot  = 3'd0;
    steal_slot  = 3'd0;
    steal_rank  = rank_q[0];
    for (int v = 0; v < NUM_VOICES; v++) begin
      match[v] = active_q[v] && (note_q[v] == key_note);
      if (!active_q[v] && !free_found) begin
        free_found = 1'b1;
        free_slot  = 3'(v);
      end
      if (match[v] && !match_found) begin
        match_found = 1'b1;
        match_slot  = 3'(v);
      end
    end
    // A strict greater-than comparison gives ties to the lowest index.
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (rank_q[v] > steal_rank) begin
        steal_rank = rank_q[v];
        steal_slot = 3'(v);
      end
    end
    alloc_slot = free_found ? free_slot : steal_slot;
  end

  always_comb begin
    state_d     = state_q;
    oct_d       = oct_q;
    active_d    = active_q;
    note_d      = note_q;
    rank_d      = rank_q;
    evt_valid_d = 1'b0;
    evt_voice_d = evt_voice_q;
    evt_on_d    = evt_on_q;
    do_make     = 1'b0;
    do_break    = 1'b0;

    if (received_data_en) begin
      case (state_q)
        S_IDLE: begin
          if (received_data == CODE_BRK)      state_d = S_BRK;
          else if (received_data == CODE_EXT) state_d = S_EXT;
          else                                do_make = 1'b1;
        end
        S_BRK: begin
          do_break = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT:     state_d = (received_data == CODE_BRK) ? S_EXT_BRK : S_IDLE;
        S_EXT_BRK: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end

    if (do_make && received_data == CODE_ODN && oct_q != 3'd0) oct_d = oct_q - 3'd1;
    if (do_make && received_data == CODE_OUP && oct_q != 3'd7) oct_d = oct_q + 3'd1;

    // A typematic repeat of a note that is already sounding is ignored.
    if (do_make && key_hit && !match_found) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (3'(v) == alloc_slot) begin
          active_d[v] = 1'b1;
          note_d[v]   = key_note;
          rank_d[v]   = 3'd0;
        end else if (active_q[v] && rank_q[v] != RANK_MAX) begin
          rank_d[v] = rank_q[v] + 3'd1;
        end
      end
      evt_valid_d = 1'b1;
      evt_voice_d = alloc_slot;
      evt_on_d    = 1'b1;
    end

    // A break uses the current octave, so a note held across an octave change is not released.
    if (do_break && key_hit && match_found) begin
      active_d    = active_q & ~match;
      evt_valid_d = 1'b1;
      evt_voice_d = match_slot;
      evt_on_d    = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      oct_q       <= OCT_RST;
      active_q    <= '0;
      note_q      <= '0;
      rank_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_voice_q <= 3'd0;
      evt_on_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      oct_q       <= oct_d;
      active_q    <= active_d;
      note_q      <= note_d;
      rank_q      <= rank_d;
      evt_valid_q <= evt_valid_d;
      evt_voice_q <= evt_voice_d;
      evt_on_q    <= evt_on_d;
    end
  end

  assign voice_active = active_q;
  assign voice_note   = note_q;
  assign evt_valid    = evt_valid_q;
  assign evt_voice    = evt_voice_q;
  assign evt_on       = evt_on_q;
  assign octave       = oct_q;

endmodule
